// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types for the bus arbiter: access size encoding, FSM states, index width helper
package bus_pkg;

  // Access size carried on m_size / mem_size
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Arbiter transaction states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Width of a master index; a single master still needs a 1-bit index
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master request/response bundle plus memory-side strobes for the bus arbiter
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]             m_rd;
  logic [NUM_MASTERS-1:0]             m_we;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0][1:0]        m_size;
  logic [NUM_MASTERS-1:0]             m_lock;
  logic [NUM_MASTERS-1:0]             m_ack;
  logic [NUM_MASTERS-1:0]             m_err;
  logic [DATA_W-1:0]                  m_rdata;

  logic                               mem_rd;
  logic                               mem_we;
  logic [ADDR_W-1:0]                  mem_addr;
  logic [DATA_W-1:0]                  mem_wdata;
  logic [1:0]                         mem_size;
  logic [DATA_W-1:0]                  mem_rdata;
  logic                               mem_err;

  // Arbiter side
  modport slave (
    input  m_rd, m_we, m_addr, m_wdata, m_size, m_lock,
    output m_ack, m_err, m_rdata,
    output mem_rd, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_rdata, mem_err
  );

  // Requesters and memory model side
  modport master (
    output m_rd, m_we, m_addr, m_wdata, m_size, m_lock,
    input  m_ack, m_err, m_rdata,
    input  mem_rd, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_rdata, mem_err
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin pick: first requester at or after the pointer
module rr_picker
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic                   o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan masters starting at the pointer, wrapping modulo NUM_MASTERS; first hit wins
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_MASTERS);
      if (!o_valid && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin multi-master arbiter onto one memory port; optional grant lock via ARB_LOCK_EN
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int         IDX_W     = idx_w(NUM_MASTERS);
  // Last WAIT count value; only meaningful when MEM_LATENCY > 1
  localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 2);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_gnt_idx;
  logic [IDX_W-1:0]       w_pick_idx;
  logic [IDX_W-1:0]       w_next_ptr;
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_pick_oh;
  logic                   w_pick_vld;
  logic                   w_grant;
  logic                   w_keep;
  logic                   w_illegal;
  logic [NUM_MASTERS-1:0] r_ack;
  logic [NUM_MASTERS-1:0] r_err;
  logic [DATA_W-1:0]      r_rdata;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [1:0]             r_size;
  logic                   r_rd;
  logic                   r_we;
  logic [3:0]             r_cnt;

  assign w_req     = bus.m_rd | bus.m_we;
  assign w_illegal = r_rd & r_we;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_oh),
    .o_valid (w_pick_vld)
  );

  // One-hot grant to master index
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_pick_oh[i]) w_pick_idx = IDX_W'(i);
    end
  end

  assign w_next_ptr = (r_gnt_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_gnt_idx + 1'b1;

`ifdef ARB_LOCK_EN
  assign w_keep = bus.m_lock[r_gnt_idx];
`else
  logic w_lock_unused;
  assign w_keep        = 1'b0;
  assign w_lock_unused = ^bus.m_lock;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state; no grant in the ack cycle since the acked master's request line still reflects the finished access
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld && (r_ack == '0)) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (MEM_LATENCY > 1) w_state_nxt = ST_WAIT;
        else                 w_state_nxt = ST_RESP;
      end
      ST_WAIT: begin
        if (r_cnt == WAIT_LAST) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the granted master's request fields; they drive the memory port for the whole transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt_idx <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_rd      <= 1'b0;
      r_we      <= 1'b0;
    end else if (w_grant) begin
      r_gnt_idx <= w_pick_idx;
      r_addr    <= bus.m_addr[w_pick_idx];
      r_wdata   <= bus.m_wdata[w_pick_idx];
      r_size    <= bus.m_size[w_pick_idx];
      r_rd      <= bus.m_rd[w_pick_idx];
      r_we      <= bus.m_we[w_pick_idx];
    end
  end

  // Memory latency counter, restarted by every ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_cnt <= '0;
    else if (r_state == ST_ISSUE)   r_cnt <= '0;
    else if (r_state == ST_WAIT)    r_cnt <= r_cnt + 1'b1;
  end

  // Response capture, one-cycle ack pulse and round-robin pointer advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack    <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      if (r_state == ST_RESP) begin
        r_ack[r_gnt_idx] <= 1'b1;
        r_err[r_gnt_idx] <= w_illegal | bus.mem_err;
        if (!w_illegal) r_rdata <= bus.mem_rdata;
        r_rr_ptr <= w_keep ? r_gnt_idx : w_next_ptr;
      end
    end
  end

  // A simultaneous read+write is never strobed to memory
  assign bus.mem_rd    = (r_state == ST_ISSUE) && r_rd && !r_we;
  assign bus.mem_we    = (r_state == ST_ISSUE) && r_we && !r_rd;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_size  = r_size;
  assign bus.m_ack     = r_ack;
  assign bus.m_err     = r_err;
  assign bus.m_rdata   = r_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench: directed cases plus randomized rounds against a transaction-level model
module tb_bus_arbiter;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_rstb   = 0;
  int   n_wstb   = 0;
  bit   env_ready = 1'b0;
  logic [31:0] mem_env   [4];
  logic [31:0] model_mem [4];

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus_a ();
  bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus_b ();

  bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
  );
  bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
  );

  assign bus_b.mem_rdata = 32'hCAFE_0001;
  assign bus_b.mem_err   = 1'b0;

  function automatic logic [31:0] init_word(input int k);
    return 32'(32'h1111_1111 * (k + 1));
  endfunction

  // Memory environment for dut_a: 4 words selected by addr[9:8], error on 0xFFFF_FFF0
  always @(negedge clk) begin
    if (!env_ready) begin
      for (int k = 0; k < 4; k++) mem_env[k] = init_word(k);
      env_ready = 1'b1;
    end
    if (bus_a.mem_we) begin
      mem_env[bus_a.mem_addr[9:8]] = bus_a.mem_wdata;
      n_wstb++;
    end
    if (bus_a.mem_rd) n_rstb++;
    bus_a.mem_rdata = mem_env[bus_a.mem_addr[9:8]];
    bus_a.mem_err   = (bus_a.mem_addr == 32'hFFFF_FFF0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_a(input int m, input logic rd, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus_a.m_rd[m]    = rd;
    bus_a.m_we[m]    = we;
    bus_a.m_addr[m]  = addr;
    bus_a.m_wdata[m] = wdata;
    bus_a.m_size[m]  = SIZE_WORD;
  endtask

  task automatic drop_a(input int m);
    bus_a.m_rd[m] = 1'b0;
    bus_a.m_we[m] = 1'b0;
  endtask

  task automatic wait_ack(input bit sel_b, output logic [1:0] ack, output logic [1:0] err,
                          output logic [31:0] rdata, output int cyc);
    ack = '0; err = '0; rdata = '0; cyc = 0;
    while (ack == 2'b00 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ack   = sel_b ? bus_b.m_ack   : bus_a.m_ack;
      err   = sel_b ? bus_b.m_err   : bus_a.m_err;
      rdata = sel_b ? bus_b.m_rdata : bus_a.m_rdata;
    end
  endtask

  task automatic chk_outputs_zero(input bit sel_b, input string pfx);
    if (sel_b) begin
      chk({pfx, "_ack"}, bus_b.m_ack, 0);        chk({pfx, "_err"}, bus_b.m_err, 0);
      chk({pfx, "_rdata"}, bus_b.m_rdata, 0);    chk({pfx, "_mem_rd"}, bus_b.mem_rd, 0);
      chk({pfx, "_mem_we"}, bus_b.mem_we, 0);    chk({pfx, "_mem_addr"}, bus_b.mem_addr, 0);
      chk({pfx, "_mem_wdata"}, bus_b.mem_wdata, 0); chk({pfx, "_mem_size"}, bus_b.mem_size, 0);
    end else begin
      chk({pfx, "_ack"}, bus_a.m_ack, 0);        chk({pfx, "_err"}, bus_a.m_err, 0);
      chk({pfx, "_rdata"}, bus_a.m_rdata, 0);    chk({pfx, "_mem_rd"}, bus_a.mem_rd, 0);
      chk({pfx, "_mem_we"}, bus_a.mem_we, 0);    chk({pfx, "_mem_addr"}, bus_a.mem_addr, 0);
      chk({pfx, "_mem_wdata"}, bus_a.mem_wdata, 0); chk({pfx, "_mem_size"}, bus_a.mem_size, 0);
    end
  endtask

  initial begin
    logic [1:0]  ack, err, mask;
    logic [31:0] rdv;
    int          cyc, mp, exp_m, legal, base, sel, seen;
    bit          first;
    logic        op_rd [2];
    logic        op_we [2];
    int          op_slot [2];
    logic [31:0] op_wd [2];
    int          q[$];
    int          exp_seq [4];

    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.m_rd = '0; bus_a.m_we = '0; bus_a.m_addr = '0; bus_a.m_wdata = '0;
    bus_a.m_size = '0; bus_a.m_lock = '0;
    bus_b.m_rd = '0; bus_b.m_we = '0; bus_b.m_addr = '0; bus_b.m_wdata = '0;
    bus_b.m_size = '0; bus_b.m_lock = '0;
    for (int k = 0; k < 4; k++) model_mem[k] = init_word(k);

    repeat (2) @(negedge clk);
    chk_outputs_zero(1'b0, "rst_a");
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Write then read on an idle bus
    req_a(0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    wait_ack(1'b0, ack, err, rdv, cyc);
    chk("wr_ack", ack, 2'b01); chk("wr_lat", cyc, 3); chk("wr_err", err, 0);
    drop_a(0);
    model_mem[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ack_one_cycle", bus_a.m_ack, 0);
    req_a(0, 1'b1, 1'b0, 32'h100, 32'h0);
    wait_ack(1'b0, ack, err, rdv, cyc);
    chk("rd_ack", ack, 2'b01); chk("rd_lat", cyc, 3); chk("rd_data", rdv, 32'hDEAD_BEEF);
    drop_a(0);
    @(negedge clk);
    chk("rdata_hold", bus_a.m_rdata, 32'hDEAD_BEEF);

    // Read and write together: no strobe, error ack
    base = n_rstb + n_wstb;
    req_a(1, 1'b1, 1'b1, 32'h200, 32'h5555_AAAA);
    wait_ack(1'b0, ack, err, rdv, cyc);
    chk("ill_ack", ack, 2'b10); chk("ill_err", err, 2'b10); chk("ill_lat", cyc, 3);
    chk("ill_no_strobe", (n_rstb + n_wstb) - base, 0);
    drop_a(1);
    @(negedge clk);

    // Memory error on one read, clean on the next
    req_a(0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    wait_ack(1'b0, ack, err, rdv, cyc);
    chk("merr_ack", ack, 2'b01); chk("merr_err", err, 2'b01);
    drop_a(0);
    @(negedge clk);
    req_a(0, 1'b1, 1'b0, 32'h100, 32'h0);
    wait_ack(1'b0, ack, err, rdv, cyc);
    chk("merr_next_err", err, 0); chk("merr_next_data", rdv, 32'hDEAD_BEEF);
    drop_a(0);
    @(negedge clk);

    // Randomized rounds from a reset pointer
    rst_a = 1'b0;
    #1 chk("rst_pulse_ack", bus_a.m_ack, 0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    mp = 0;
    for (int r = 0; r < 24; r++) begin
      mask  = 2'($urandom_range(1, 3));
      base  = n_rstb + n_wstb;
      legal = 0;
      for (int m = 0; m < 2; m++) begin
        if (mask[m]) begin
          sel        = int'($urandom_range(0, 9));
          op_rd[m]   = (sel == 0) || (sel >= 5);
          op_we[m]   = (sel <= 4);
          op_slot[m] = int'($urandom_range(0, 3));
          op_wd[m]   = $urandom;
          req_a(m, op_rd[m], op_we[m], 32'(op_slot[m]) << 8, op_wd[m]);
          if (!(op_rd[m] && op_we[m])) legal++;
        end
      end
      q.delete();
      for (int k = 0; k < 2; k++) if (mask[(mp + k) % 2]) q.push_back((mp + k) % 2);
      first = 1'b1;
      while (q.size() > 0) begin
        exp_m = q.pop_front();
        wait_ack(1'b0, ack, err, rdv, cyc);
        chk("rnd_who", ack, 2'b01 << exp_m);
        if (first) chk("rnd_lat", cyc, 3);
        first = 1'b0;
        if (op_rd[exp_m] && op_we[exp_m]) begin
          chk("rnd_err_ill", err, 2'b01 << exp_m);
        end else begin
          chk("rnd_err", err, 0);
          if (op_rd[exp_m]) chk("rnd_rdata", rdv, model_mem[op_slot[exp_m]]);
          else              model_mem[op_slot[exp_m]] = op_wd[exp_m];
        end
        for (int m = 0; m < 2; m++) if (ack[m]) drop_a(m);
        drop_a(exp_m);
        mp = (exp_m + 1) % 2;
      end
      @(negedge clk);
      chk("rnd_strobes", (n_rstb + n_wstb) - base, legal);
    end

    // Continuous requests from both masters; master 0 locks for its first two grants
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
`ifdef ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    req_a(0, 1'b1, 1'b0, 32'h000, 32'h0);
    req_a(1, 1'b1, 1'b0, 32'h300, 32'h0);
    bus_a.m_lock[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b0, ack, err, rdv, cyc);
      chk("cont_who", ack, 2'b01 << exp_seq[i]);
      chk("cont_rdata", rdv, model_mem[(exp_seq[i] == 0) ? 0 : 3]);
      if (i == 1) bus_a.m_lock[0] = 1'b0;
    end
    drop_a(0); drop_a(1);
    repeat (2) @(negedge clk);

    // Longer latency: full transaction, reset in WAIT, then a fresh transaction
    bus_b.m_rd[0] = 1'b1; bus_b.m_addr[0] = 32'h300; bus_b.m_wdata[0] = 32'h1234_5678;
    bus_b.m_size[0] = SIZE_WORD;
    wait_ack(1'b1, ack, err, rdv, cyc);
    chk("b_ack", ack, 2'b01); chk("b_lat", cyc, 5); chk("b_rdata", rdv, 32'hCAFE_0001);
    bus_b.m_rd[0] = 1'b0;
    @(negedge clk);
    bus_b.m_rd[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_addr_pre_rst", bus_b.mem_addr, 32'h300);
    rst_b = 1'b0;
    #1 chk_outputs_zero(1'b1, "b_rst");
    bus_b.m_rd[0] = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_b.m_ack != 2'b00) seen++;
    end
    chk("b_no_ack_after_rst", seen, 0);
    bus_b.m_rd[0] = 1'b1;
    wait_ack(1'b1, ack, err, rdv, cyc);
    chk("b2_ack", ack, 2'b01); chk("b2_lat", cyc, 5);
    bus_b.m_rd[0] = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
